free_list: RTL and testbench



---
 rtl/free_list.sv | 147 ++++++++++++++
 tb/tb_free_list.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/free_list.sv
// free_list: circular FIFO of free physical register tags feeding rename.
// Dispatch sees up to TABLE_WRITE candidate tags from the head; ROB commit
// pushes released tags at the tail; branch recovery makes the whole ring
// free again in one cycle by snapping head onto the post-retire tail.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   alloc_en_i          per-slot allocation request (contiguous from bit 0)
//   free_tag_o          candidate tags, slot i = entry[head+i]
//   free_valid_o        slot i has a tag (count > i)
//   retire_en_i         per-slot release valid from ROB commit
//   retire_tag_i        tag being released (tag 0 is never freed)
//   branch_recover_i    mispredict recovery, alloc ignored that cycle
//   free_count_o        number of free tags
//   error_o             sticky over/underflow flag, cleared by reset only

// Per-slot read port: tag and availability for dispatch slot SLOT.
module free_list_slot #(
  parameter int FL_SIZE = 32,
  parameter int TAG_W   = 6,
  parameter int PTR_W   = 5,
  parameter int CNT_W   = 6,
  parameter int SLOT    = 0
) (
  input  logic [FL_SIZE-1:0][TAG_W-1:0] entry,
  input  logic [PTR_W-1:0]              head,
  input  logic [CNT_W-1:0]              count,
  output logic [TAG_W-1:0]              tag,
  output logic                          valid
);
  logic [PTR_W-1:0] idx;
  // Natural PTR_W-bit wrap gives the modulo FL_SIZE indexing.
  assign idx   = head + PTR_W'(SLOT);
  assign tag   = entry[idx];
  assign valid = count > CNT_W'(SLOT);
endmodule

module free_list #(
  parameter int ARCHREG_NUMBER = 32,
  parameter int PREG_NUMBER    = 64,
  parameter int TABLE_WRITE    = 2,
  // Must be a power of two: pointers wrap by truncation.
  parameter int FL_SIZE        = PREG_NUMBER - ARCHREG_NUMBER
) (
  input  logic                                           clk,
  input  logic                                           reset,
  input  logic [TABLE_WRITE-1:0]                         alloc_en_i,
  output logic [TABLE_WRITE-1:0][$clog2(PREG_NUMBER)-1:0] free_tag_o,
  output logic [TABLE_WRITE-1:0]                         free_valid_o,
  input  logic [TABLE_WRITE-1:0]                         retire_en_i,
  input  logic [TABLE_WRITE-1:0][$clog2(PREG_NUMBER)-1:0] retire_tag_i,
  input  logic                                           branch_recover_i,
  output logic [$clog2(FL_SIZE):0]                       free_count_o,
  output logic                                           error_o
);
  localparam int TAG_W = $clog2(PREG_NUMBER);
  localparam int PTR_W = $clog2(FL_SIZE);
  localparam int CNT_W = PTR_W + 1;

  logic [FL_SIZE-1:0][TAG_W-1:0]     entry;
  logic [PTR_W-1:0]                  head, tail;
  logic [CNT_W-1:0]                  count;
  logic                              error;

  logic [CNT_W-1:0]                  nalloc, nacc;
  logic [CNT_W:0]                    space;
  logic                              underflow, overflow;
  logic [TABLE_WRITE-1:0]            push_ok;
  logic [TABLE_WRITE-1:0][PTR_W-1:0] wr_idx;
  logic [PTR_W-1:0]                  tail_nxt;

  genvar g;
  generate
    for (g = 0; g < TABLE_WRITE; g++) begin : g_slot
      free_list_slot #(
        .FL_SIZE(FL_SIZE), .TAG_W(TAG_W), .PTR_W(PTR_W), .CNT_W(CNT_W), .SLOT(g)
      ) u_slot (
        .entry(entry),
        .head (head),
        .count(count),
        .tag  (free_tag_o[g]),
        .valid(free_valid_o[g])
      );
    end
  endgenerate

  // Allocation count; recovery cancels dispatch entirely.
  always_comb begin
    nalloc    = '0;
    underflow = 1'b0;
    if (!branch_recover_i) begin
      for (int i = 0; i < TABLE_WRITE; i++) begin
        if (alloc_en_i[i] && free_valid_o[i]) nalloc = nalloc + CNT_W'(1);
        if (alloc_en_i[i] && !free_valid_o[i]) underflow = 1'b1;
      end
    end
  end

  // Retire pushes are compacted in slot order. Entries consumed by this
  // cycle's allocation count as room since their tag is read before the edge.
  always_comb begin
    space    = (CNT_W+1)'(FL_SIZE) - {1'b0, count} + {1'b0, nalloc};
    nacc     = '0;
    overflow = 1'b0;
    push_ok  = '0;
    wr_idx   = '0;
    for (int i = 0; i < TABLE_WRITE; i++) begin
      wr_idx[i] = tail + nacc[PTR_W-1:0];
      if (retire_en_i[i] && retire_tag_i[i] != '0) begin
        if ({1'b0, nacc} < space) begin
          push_ok[i] = 1'b1;
          nacc       = nacc + CNT_W'(1);
        end else begin
          overflow = 1'b1;
        end
      end
    end
    tail_nxt = tail + nacc[PTR_W-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < FL_SIZE; k++) entry[k] <= TAG_W'(ARCHREG_NUMBER + k);
      head  <= '0;
      tail  <= '0;
      count <= CNT_W'(FL_SIZE);
      error <= 1'b0;
    end else begin
      for (int i = 0; i < TABLE_WRITE; i++)
        if (push_ok[i]) entry[wr_idx[i]] <= retire_tag_i[i];
      tail <= tail_nxt;
      if (branch_recover_i) begin
        // Slots from the new tail round to it still hold the in-flight tags,
        // so the full ring is free again.
        head  <= tail_nxt;
        count <= CNT_W'(FL_SIZE);
      end else begin
        head  <= head + nalloc[PTR_W-1:0];
        count <= count - nalloc + nacc;
      end
      error <= error | underflow | overflow;
    end
  end

  assign free_count_o = count;
  assign error_o      = error;
endmodule

// File: tb/tb_free_list.sv
module tb_free_list;
  localparam int F = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic [1:0]      alloc_en;
  logic [1:0][5:0] free_tag;
  logic [1:0]      free_valid;
  logic [1:0]      retire_en;
  logic [1:0][5:0] retire_tag;
  logic            recover;
  logic [5:0]      free_count;
  logic            error;

  int checks = 0;
  int errors = 0;

  // Reference: ring of F tags with integer head/tail/count.
  int m_mem[F];
  int m_hd, m_tl, m_cnt;
  bit m_err;

  free_list dut (
    .clk(clk), .reset(reset),
    .alloc_en_i(alloc_en), .free_tag_o(free_tag), .free_valid_o(free_valid),
    .retire_en_i(retire_en), .retire_tag_i(retire_tag),
    .branch_recover_i(recover), .free_count_o(free_count), .error_o(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < F; k++) m_mem[k] = 32 + k;
    m_hd = 0; m_tl = 0; m_cnt = F; m_err = 0;
  endtask

  task automatic model_check();
    logic [1:0][5:0] et;
    logic [1:0]      ev;
    for (int i = 0; i < 2; i++) begin
      et[i] = 6'(m_mem[(m_hd + i) % F]);
      ev[i] = m_cnt > i;
    end
    chk("tag", 32'(free_tag), 32'(et));
    chk("valid", 32'(free_valid), 32'(ev));
    chk("count", 32'(free_count), 32'(m_cnt));
    chk("error", 32'(error), 32'(m_err));
  endtask

  task automatic model_step(input logic [1:0] a, input logic [1:0] r,
                            input logic [5:0] t0, input logic [5:0] t1, input logic rec);
    int nal, room, acc;
    int tg[2];
    bit uf, ovf;
    tg[0] = t0; tg[1] = t1;
    nal = 0; acc = 0; uf = 0; ovf = 0;
    if (!rec)
      for (int i = 0; i < 2; i++)
        if (a[i]) begin
          if (m_cnt > i) nal++; else uf = 1;
        end
    room = F - m_cnt + nal;
    for (int i = 0; i < 2; i++)
      if (r[i] && tg[i] != 0) begin
        if (acc < room) begin
          m_mem[(m_tl + acc) % F] = tg[i];
          acc++;
        end else ovf = 1;
      end
    m_tl = (m_tl + acc) % F;
    if (rec) begin
      m_hd = m_tl; m_cnt = F;
    end else begin
      m_hd = (m_hd + nal) % F; m_cnt = m_cnt - nal + acc;
    end
    m_err = m_err | uf | ovf;
  endtask

  // One clock: check state, drive inputs, let the edge happen, go idle.
  task automatic cyc(input logic [1:0] a, input logic [1:0] r,
                     input logic [5:0] t0, input logic [5:0] t1, input logic rec);
    @(negedge clk);
    model_check();
    alloc_en = a; retire_en = r; retire_tag[0] = t0; retire_tag[1] = t1; recover = rec;
    @(posedge clk);
    model_step(a, r, t0, t1, rec);
    #1;
    alloc_en = '0; retire_en = '0; retire_tag = '0; recover = 1'b0;
  endtask

  task automatic check_reset_vals(input string nm);
    chk({nm, "_tag"}, 32'(free_tag), {20'd0, 6'd33, 6'd32});
    chk({nm, "_valid"}, 32'(free_valid), 32'd3);
    chk({nm, "_count"}, 32'(free_count), 32'd32);
    chk({nm, "_error"}, 32'(error), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    alloc_en = '0; retire_en = '0; retire_tag = '0; recover = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [1:0] a, r;
    logic [5:0] t0, t1;
    reset = 1'b1;
    alloc_en = '0; retire_en = '0; retire_tag = '0; recover = 1'b0;
    model_reset();
    #12;
    check_reset_vals("rst");
    reset = 1'b0;
    @(negedge clk);
    check_reset_vals("idle");

    // Drain all 32 tags, then one refused request.
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk("drain_tag0", 32'(free_tag[0]), 32'(32 + 2 * k));
      cyc(2'b11, 2'b00, 6'd0, 6'd0, 1'b0);
    end
    @(negedge clk);
    chk("empty_count", 32'(free_count), 32'd0);
    chk("empty_valid", 32'(free_valid), 32'd0);
    cyc(2'b11, 2'b00, 6'd0, 6'd0, 1'b0);
    @(negedge clk);
    chk("uf_error", 32'(error), 32'd1);
    chk("uf_count", 32'(free_count), 32'd0);

    cyc(2'b00, 2'b11, 6'd40, 6'd41, 1'b0);
    @(negedge clk);
    chk("ret_tag", 32'(free_tag), {20'd0, 6'd41, 6'd40});
    chk("ret_count", 32'(free_count), 32'd2);

    cyc(2'b00, 2'b11, 6'd0, 6'd45, 1'b0);
    @(negedge clk);
    chk("zero_count", 32'(free_count), 32'd3);

    // Count 1 with simultaneous alloc and retire: no bypass.
    cyc(2'b01, 2'b00, 6'd0, 6'd0, 1'b0);
    cyc(2'b01, 2'b00, 6'd0, 6'd0, 1'b0);
    @(negedge clk);
    chk("c1_count", 32'(free_count), 32'd1);
    chk("c1_tag0", 32'(free_tag[0]), 32'd45);
    cyc(2'b01, 2'b01, 6'd50, 6'd0, 1'b0);
    @(negedge clk);
    chk("c1_count_after", 32'(free_count), 32'd1);
    chk("c1_tag_after", 32'(free_tag[0]), 32'd50);

    // Wrap: head = tail = 31 serves entry[31] then entry[0].
    do_reset();
    for (int k = 0; k < 15; k++) cyc(2'b11, 2'b00, 6'd0, 6'd0, 1'b0);
    cyc(2'b01, 2'b00, 6'd0, 6'd0, 1'b0);
    for (int k = 0; k < 15; k++) cyc(2'b00, 2'b11, 6'(2 * k + 1), 6'(2 * k + 2), 1'b0);
    cyc(2'b00, 2'b01, 6'd31, 6'd0, 1'b0);
    @(negedge clk);
    chk("wrap_tag", 32'(free_tag), {20'd0, 6'd1, 6'd63});
    chk("wrap_count", 32'(free_count), 32'd32);

    // Recovery: returned tags 10,11,12 land in entry[0..2] over 32..34,
    // so the ring restarts at entry[3] = 35.
    do_reset();
    for (int k = 0; k < 3; k++) cyc(2'b11, 2'b00, 6'd0, 6'd0, 1'b0);
    cyc(2'b00, 2'b11, 6'd10, 6'd11, 1'b0);
    cyc(2'b11, 2'b01, 6'd12, 6'd0, 1'b1);
    @(negedge clk);
    chk("rec_count", 32'(free_count), 32'd32);
    chk("rec_tag0", 32'(free_tag[0]), 32'd35);
    chk("rec_error", 32'(error), 32'd0);

    // Asynchronous reset between edges, mid-burst.
    for (int k = 0; k < 3; k++) cyc(2'b11, 2'b01, 6'd7, 6'd0, 1'b0);
    #1;
    reset = 1'b1;
    #1;
    check_reset_vals("async");
    model_reset();
    #1;
    reset = 1'b0;

    // Randomized traffic against the reference ring.
    for (int n = 0; n < 2000; n++) begin
      if (n % 400 == 399) do_reset();
      case ($urandom_range(0, 2))
        0: a = 2'b00;
        1: a = 2'b01;
        default: a = 2'b11;
      endcase
      r  = 2'($urandom_range(0, 3));
      t0 = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
      t1 = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
      cyc(a, r, t0, t1, $urandom_range(0, 39) == 0);
    end
    @(negedge clk);
    model_check();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
